// File: rtl/uart_rx_fifo_if.sv
// Bus between a uart_receiver/consumer (master) and uart_rx_fifo (slave).
// Carries the receiver levels, flush, pop request and FIFO status.
interface uart_rx_fifo_if #(
  parameter int CW = 4
);
  logic [7:0]    Rx_DATA;
  logic          Rx_VALID;
  logic          Rx_FERROR;
  logic          Rx_PERROR;
  logic          clr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_ferr;
  logic          rd_perr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_cnt;

  modport master (
    output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, clr, rd_en,
    input  rd_data, rd_ferr, rd_perr, empty, full, count, overflow, drop_cnt
  );

  modport slave (
    input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, clr, rd_en,
    output rd_data, rd_ferr, rd_perr, empty, full, count, overflow, drop_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: one entry per frame, FWFT read side.
// Define UART_RX_FIFO_DROP_ERR_EN to discard errored frames and count them.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          empty_q;
  logic          full_q;
  logic          overflow_q;
  logic          ev_q;
  logic          ev;
  logic          wr_ev;
  logic          store;
  logic          do_rd;
  logic          do_wr;
  logic          lost;
  logic [9:0]    head;

  // One write event per frame: rising edge of any receiver level.
  assign ev    = bus.Rx_VALID | bus.Rx_FERROR | bus.Rx_PERROR;
  assign wr_ev = ev & ~ev_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic       rx_err;
  logic       drop_ev;
  logic [7:0] drop_q;

  assign rx_err  = bus.Rx_FERROR | bus.Rx_PERROR;
  assign store   = wr_ev & ~rx_err;
  assign drop_ev = wr_ev & rx_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (bus.clr) begin
      drop_q <= '0;
    end else if (drop_ev && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_q;
`else
  assign store        = wr_ev;
  assign bus.drop_cnt = '0;
`endif

  // A pop while full frees the slot the simultaneous push needs.
  assign do_rd = bus.rd_en & ~empty_q & ~bus.clr;
  assign do_wr = store & (~full_q | bus.rd_en) & ~bus.clr;
  assign lost  = store & full_q & ~bus.rd_en & ~bus.clr;

  assign count_nxt = count_q + CW'(do_wr) - CW'(do_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_q       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ev_q <= ev;
      if (bus.clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_q    <= '0;
        empty_q    <= 1'b1;
        full_q     <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        if (lost)  overflow_q <= 1'b1;
        count_q <= count_nxt;
        empty_q <= (count_nxt == '0);
        full_q  <= (count_nxt == CW'(DEPTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {bus.Rx_DATA, bus.Rx_FERROR, bus.Rx_PERROR};
  end

  assign head = mem[rd_ptr];

  assign bus.rd_data  = empty_q ? '0 : head[9:2];
  assign bus.rd_ferr  = empty_q ? 1'b0 : head[1];
  assign bus.rd_perr  = empty_q ? 1'b0 : head[0];
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo against a queue-based model.
// Follows UART_RX_FIFO_DROP_ERR_EN if defined at compile time.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.CW(CW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Model: FIFO contents as {data, ferr, perr}; exp_q is the scoreboard.
  logic [9:0] model_q[$];
  logic [9:0] exp_q[$];
  bit         ev_prev;
  bit         ovf;
  int         drops;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", int'(bus.count), model_q.size());
    chk("empty", int'(bus.empty), int'(model_q.size() == 0));
    chk("full", int'(bus.full), int'(model_q.size() == DEPTH));
    chk("overflow", int'(bus.overflow), int'(ovf));
    chk("drop_cnt", int'(bus.drop_cnt), drops);
    if (model_q.size() > 0) begin
      chk("head_data", int'(bus.rd_data), int'(model_q[0][9:2]));
      chk("head_tags", int'({bus.rd_ferr, bus.rd_perr}), int'(model_q[0][1:0]));
    end else begin
      chk("empty_out", int'({bus.rd_data, bus.rd_ferr, bus.rd_perr}), 0);
    end
  endtask

  task automatic model_update(input bit v, input bit f, input bit p,
                              input logic [7:0] d, input bit rd, input bit c);
    bit ev;
    bit wev;
    bit err;
    bit was_full;
    bit store;
    ev       = v | f | p;
    wev      = ev && !ev_prev;
    ev_prev  = ev;
    err      = f | p;
    was_full = (model_q.size() == DEPTH);
    if (c) begin
      model_q.delete();
      exp_q.delete();
      ovf   = 1'b0;
      drops = 0;
      return;
    end
    store = wev && !(DROP_EN && err);
    if (DROP_EN && wev && err && drops < 255) drops++;
    if (rd && model_q.size() > 0) void'(model_q.pop_front());
    if (store) begin
      if (was_full && !rd) ovf = 1'b1;
      else begin
        model_q.push_back({d, f, p});
        exp_q.push_back({d, f, p});
      end
    end
  endtask

  // One clock: check state left by the previous edge, drive, then advance model.
  task automatic step(input bit v, input bit f, input bit p,
                      input logic [7:0] d, input bit rd, input bit c);
    @(negedge clk);
    check_state();
    bus.Rx_VALID  = v;
    bus.Rx_FERROR = f;
    bus.Rx_PERROR = p;
    bus.Rx_DATA   = d;
    bus.rd_en     = rd;
    bus.clr       = c;
    #3;
    model_update(v, f, p, d, rd, c);
  endtask

  task automatic frame(input logic [7:0] d, input bit f, input bit p);
    step(1'b1, f, p, d, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drive_idle();
    bus.Rx_VALID  = 1'b0;
    bus.Rx_FERROR = 1'b0;
    bus.Rx_PERROR = 1'b0;
    bus.Rx_DATA   = 8'h00;
    bus.rd_en     = 1'b0;
    bus.clr       = 1'b0;
  endtask

  // Asserts reset between edges so its effect is checked asynchronously.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive_idle();
    #1;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
    model_q.delete();
    exp_q.delete();
    ev_prev = 1'b0;
    ovf     = 1'b0;
    drops   = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every accepted pop must present the oldest expected entry.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && bus.rd_en && !bus.empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got 0x%0h expected none", bus.rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_entry", int'({bus.rd_data, bus.rd_ferr, bus.rd_perr}), int'(e));
        end
      end
    end
  end

  initial begin
    bit v, f, p, rd, c;
    logic [7:0] d;
    int rd_pct;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_idle();
    do_reset();

    // Two frames, then one pop.
    frame(8'hA5, 1'b0, 1'b0);
    frame(8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Level held 50 cycles is one frame.
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("held_level_count", int'(bus.count), 1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Nine frames into eight slots, then drain.
    for (int i = 0; i < 9; i++) frame(8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("overfill_overflow", int'(bus.overflow), 1);
    // Push while full with a pop on the same edge.
    step(1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_rw_count", int'(bus.count), DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);  // pop on empty is ignored
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Errored frames, then push+pop on empty.
    frame(8'h7E, 1'b0, 1'b1);
    frame(8'h42, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset with three entries held.
    frame(8'h01, 1'b0, 1'b0);
    frame(8'h02, 1'b0, 1'b0);
    frame(8'h03, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();

    // Random traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      rd_pct = (ph % 2 == 0) ? 10 : 70;
      for (int i = 0; i < 300; i++) begin
        v  = ($urandom_range(0, 99) < 45);
        f  = ($urandom_range(0, 99) < 8);
        p  = ($urandom_range(0, 99) < 8);
        d  = 8'($urandom);
        rd = ($urandom_range(0, 99) < rd_pct);
        c  = ($urandom_range(0, 999) < 5);
        step(v, f, p, d, rd, c);
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
